// File: rtl/nibble_serial_sub.sv
//-----------------------------------------------------------------------------
// nibble_serial_sub
//
// Purpose:
//   16-bit subtractor that computes d = (a - b) mod 2^16 one 4-bit nibble per
//   clock. The subtraction is performed as a + ~b + 1. The "+1" is the initial
//   carry. Each nibble's carry-out comes from a 4-bit generate/propagate
//   lookahead network and is registered for the next nibble.
//
// Handshake (valid/ready, both directions):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   The producer holds its payload stable while valid=1 and ready=0. The block
//   raises in_ready only in IDLE, and raises out_valid only in DONE. So an
//   accepted operation can never overlap with the next one.
//
// Timing:
//   The operand-accepting edge moves the FSM to CALC. Four CALC edges then
//   produce nibbles 0..3. out_valid rises on the 4th edge after acceptance.
//   After the result is transferred, in_ready returns on the following cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operands a/b presented
//   in_ready   out  block can accept operands (IDLE only)
//   a          in   [15:0] minuend
//   b          in   [15:0] subtrahend
//   out_valid  out  result d valid (DONE only)
//   out_ready  in   consumer accepts result
//   d          out  [15:0] registered difference
//   borrow     out  a < b unsigned        (only with SUB_FLAGS_EN)
//   zero       out  d == 0                (only with SUB_FLAGS_EN)
//   ovf        out  signed overflow       (only with SUB_FLAGS_EN)
//
// Configuration:
//   Define SUB_FLAGS_EN to add the borrow/zero/ovf ports and their logic.
//   Without it, the block produces only d, with identical timing.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module nibble_serial_sub (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] d
`ifdef SUB_FLAGS_EN
    ,
    output logic        borrow,
    output logic        zero,
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] a_q;      // captured minuend
    logic [15:0] b_q;      // captured subtrahend
    logic [1:0]  k;        // nibble index being computed in CALC
    logic        c;        // carry into nibble k

    //-------------------------------------------------------------------------
    // Nibble datapath: a_n + ~b_n + c with lookahead carries
    //-------------------------------------------------------------------------
    logic [3:0] nib_a;
    logic [3:0] nib_nb;
    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] cy;
    logic [3:0] nib_sum;

    always_comb begin
        nib_a  = a_q[{k, 2'b00} +: 4];
        nib_nb = ~b_q[{k, 2'b00} +: 4];
        gen    = nib_a & nib_nb;
        prop   = nib_a | nib_nb;

        // Each carry is a flat sum of products of g/p terms and the incoming
        // carry. No carry is built from the previous stage's carry.
        cy[0] = c;
        cy[1] = gen[0]
              | (prop[0] & c);
        cy[2] = gen[1]
              | (prop[1] & gen[0])
              | (prop[1] & prop[0] & c);
        cy[3] = gen[2]
              | (prop[2] & gen[1])
              | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & c);
        cy[4] = gen[3]
              | (prop[3] & gen[2])
              | (prop[3] & prop[2] & gen[1])
              | (prop[3] & prop[2] & prop[1] & gen[0])
              | (prop[3] & prop[2] & prop[1] & prop[0] & c);

        nib_sum = nib_a ^ nib_nb ^ cy[3:0];
    end

    //-------------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            k         <= 2'd0;
            c         <= 1'b0;
            d         <= 16'h0000;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        k        <= 2'd0;
                        c        <= 1'b1;       // the "+1" of two's complement
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end

                CALC: begin
                    d[{k, 2'b00} +: 4] <= nib_sum;
                    c                  <= cy[4];
                    k                  <= k + 2'd1;
                    if (k == 2'd3) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // Leaving DONE re-opens the input side. in_ready is
                    // registered, so it is first seen 1 in the next cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SUB_FLAGS_EN
    //-------------------------------------------------------------------------
    // Result flags, registered on the same edge that writes the last nibble
    //-------------------------------------------------------------------------
    logic [15:0] d_final;

    always_comb begin
        d_final = {nib_sum, d[11:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            borrow <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == CALC && k == 2'd3) begin
            // A missing final carry means a + ~b + 1 never reached 2^16,
            // that is a < b unsigned.
            borrow <= ~cy[4];
            zero   <= (d_final == 16'h0000);
            ovf    <= (a_q[15] != b_q[15]) && (d_final[15] != a_q[15]);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_sub.sv
`timescale 1ns/1ps
module tb_nibble_serial_sub;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] d;
`ifdef SUB_FLAGS_EN
  logic        borrow;
  logic        zero;
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  // scoreboard: expected d and flags {borrow, zero, ovf}
  logic [15:0] exp_q[$];
  logic [2:0]  exp_f_q[$];

  nibble_serial_sub dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d)
`ifdef SUB_FLAGS_EN
    ,
    .borrow    (borrow),
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model, independent of the nibble datapath
  task automatic push_expected(input logic [15:0] av, input logic [15:0] bv);
    logic [15:0] dv;
    logic [2:0]  fv;
    dv = av - bv;
    fv[2] = (av < bv);
    fv[1] = (dv == 16'h0000);
    fv[0] = (av[15] != bv[15]) && (dv[15] != av[15]);
    exp_q.push_back(dv);
    exp_f_q.push_back(fv);
  endtask

  task automatic compare_result(input string tag);
    logic [15:0] ed;
    logic [2:0]  ef;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      ed = exp_q.pop_front();
      ef = exp_f_q.pop_front();
      check16({tag, "_d"}, d, ed);
`ifdef SUB_FLAGS_EN
      check1({tag, "_borrow"}, borrow, ef[2]);
      check1({tag, "_zero"}, zero, ef[1]);
      check1({tag, "_ovf"}, ovf, ef[0]);
`endif
    end
  endtask

  // driver: one full operation with an optional DONE backpressure hold
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input int hold);
    int          waited;
    logic [15:0] dsnap;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check1({tag, "_ready_before"}, in_ready, 1'b1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    push_expected(av, bv);
    tick();  // accepting edge
    check1({tag, "_in_ready_busy"}, in_ready, 1'b0);
    check1({tag, "_out_valid_early0"}, out_valid, 1'b0);
    // inputs changing while busy must not disturb the captured operands
    for (int i = 1; i < 4; i++) begin
      a = 16'($urandom_range(0, 16'hFFFF));
      b = 16'($urandom_range(0, 16'hFFFF));
      tick();
      check1({tag, "_out_valid_early"}, out_valid, 1'b0);
    end
    a = 16'($urandom_range(0, 16'hFFFF));
    b = 16'($urandom_range(0, 16'hFFFF));
    tick();  // 4th edge after accept
    check1({tag, "_out_valid_latency"}, out_valid, 1'b1);
    check1({tag, "_in_ready_done"}, in_ready, 1'b0);
    compare_result(tag);
    dsnap = d;
    for (int i = 0; i < hold; i++) begin
      a = 16'($urandom_range(0, 16'hFFFF));
      b = 16'($urandom_range(0, 16'hFFFF));
      tick();
      check1({tag, "_hold_valid"}, out_valid, 1'b1);
      check1({tag, "_hold_in_ready"}, in_ready, 1'b0);
      check16({tag, "_hold_d"}, d, dsnap);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();  // transfer edge
    check1({tag, "_post_valid"}, out_valid, 1'b0);
    check1({tag, "_post_in_ready"}, in_ready, 1'b1);
    check16({tag, "_post_d_kept"}, d, dsnap);
    out_ready = 1'b0;
  endtask

  initial begin
    // reset state, checked without any clock edge
    #2;
    rst = 1'b1;
    #1;
    check1("reset_out_valid", out_valid, 1'b0);
    check1("reset_in_ready", in_ready, 1'b1);
    check16("reset_d", d, 16'h0000);
    tick();
    tick();
    rst = 1'b0;  // first edge with rst=0 must accept
    run_op("t_1234", 16'h1234, 16'h0234, 0);
    run_op("t_borrow_ripple", 16'h0000, 16'h0001, 0);
    run_op("t_ovf", 16'h8000, 16'h0001, 0);
    run_op("t_zero", 16'hABCD, 16'hABCD, 0);
    run_op("t_backpressure", 16'h00F0, 16'h0F00, 3);

    // reset in the 2nd CALC cycle discards the operation
    a = 16'h7777;
    b = 16'h1111;
    in_valid = 1'b1;
    tick();  // accepting edge
    in_valid = 1'b0;
    tick();  // nibble 0 written, now in 2nd CALC cycle
    check1("rstcalc_busy", in_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check1("rstcalc_out_valid", out_valid, 1'b0);
    check1("rstcalc_in_ready", in_ready, 1'b1);
    check16("rstcalc_d", d, 16'h0000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check1("rstcalc_no_result", out_valid, 1'b0);
    end
    run_op("t_after_reset", 16'h0005, 16'h0003, 0);

    // random traffic
    for (int i = 0; i < 6; i++) begin
      run_op("t_random", 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
             int'($urandom_range(0, 2)));
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_sub.md
NIBBLE_SERIAL_SUB -- requirements
Module: nibble_serial_sub

Interface
REQ-001 SHALL have no parameters; operand and result width fixed at 16 bits, processed as four 4-bit nibbles.
REQ-002 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  input  1  operands a, b presented.
REQ-005 SHALL have ports: in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports: a  input  16  minuend.
REQ-007 SHALL have ports: b  input  16  subtrahend.
REQ-008 SHALL have ports: out_valid  output  1  result d valid.
REQ-009 SHALL have ports: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports: d  output  16  registered difference a - b modulo 2^16.
REQ-011 SHALL have ports, only when SUB_FLAGS_EN is defined: borrow, zero, ovf  output  1 each  result flags.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid=1 SHALL capture a, b, set nibble index k=0, internal carry c=1, go to CALC.
REQ-014 CALC: in_ready=0, out_valid=0; each cycle SHALL compute nibble k as a[4k+3:4k] + ~b[4k+3:4k] + c, write the 4-bit sum into d[4k+3:4k], and register the nibble carry-out as the new c.
REQ-015 Nibble carry-out SHALL be derived by 4-bit generate/propagate lookahead (g = a & ~b, p = a | ~b), not by a 16-bit adder.
REQ-016 CALC SHALL last exactly 4 cycles (k = 0..3); after k=3, go to DONE.
REQ-017 Latency: out_valid SHALL rise exactly 4 rising edges after the accepting edge.
REQ-018 DONE: out_valid=1, in_ready=0; d and flags SHALL hold stable until out_valid and out_ready are both 1 on a rising edge, after which the FSM goes to IDLE.
REQ-019 No same-cycle restart: in_ready SHALL be 1 no earlier than the cycle after the result transfer.
REQ-020 in_valid, a and b SHALL be ignored in CALC and DONE; captured operands SHALL be unaffected by input changes after acceptance.
REQ-021 d SHALL keep its last completed value in IDLE; nibbles not yet written in CALC hold the prior value and SHALL NOT be treated as valid.
REQ-022 Overflow beyond 16 bits SHALL wrap: d = (a - b) mod 65536.

Reset
REQ-023 On rst=1, state SHALL immediately (asynchronously) become IDLE, with d=0, c=0, k=0, out_valid=0, in_ready=1, and all flags 0.
REQ-024 Reset asserted during CALC or DONE SHALL discard the operation; no out_valid is produced for it.
REQ-025 The first operand acceptance SHALL be possible on the first rising edge with rst=0.

Configuration
REQ-026 Macro SUB_FLAGS_EN: when defined, flag ports and logic SHALL exist and be registered together with d when entering DONE.
REQ-027 With SUB_FLAGS_EN: borrow = ~c after nibble 3 (a < b unsigned); zero = (d == 0); ovf = (a[15] != b[15]) && (d[15] != a[15]).
REQ-028 Without SUB_FLAGS_EN: flag ports SHALL be absent; all other behaviour and timing are unchanged.

Verification
REQ-029 Send a=0x1234, b=0x0234 -> d=0x1000, borrow=0, zero=0, ovf=0; out_valid exactly 4 edges after accept.
REQ-030 Send a=0x0000, b=0x0001 -> d=0xFFFF, borrow=1, ovf=0 (borrow ripples through all 4 nibbles).
REQ-031 Send a=0x8000, b=0x0001 -> d=0x7FFF, ovf=1, borrow=0; send a=0xABCD, b=0xABCD -> d=0x0000, zero=1.
REQ-032 Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> d stable, in_ready=0, new operands not captured; raise out_ready -> transfer, then in_ready=1 next cycle.
REQ-033 Assert rst in the 2nd CALC cycle -> out_valid=0, in_ready=1, d=0 without a clock edge; after release, a=0x0005, b=0x0003 -> d=0x0002.
REQ-034 Repeat REQ-029..REQ-031 with SUB_FLAGS_EN undefined -> same d values and timing, flag ports absent.
